mem_port_arbiter: RTL and testbench

//  Shares one memory port between NUM_REQ masters (matrix engine, host loader, future accelerators).
//  All sides use the engine memory protocol: op 2'b01 read, 2'b11 write, 2'b00 none; addr/wdata held; opdone pulse.

---
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one engine memory port between NUM_REQ masters, with grant lock.
// Optional watchdog enabled by defining ARB_WATCHDOG_EN.
module mem_port_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*NUM_REQ-1:0]       req_op_i,
  input  logic [32*NUM_REQ-1:0]      req_addr_i,
  input  logic [DATA_W*NUM_REQ-1:0]  req_wdata_i,
  output logic [NUM_REQ-1:0]         req_opdone_o,
  output logic [DATA_W-1:0]          req_rdata_o,
  output logic [1:0]                 mem_op_o,
  output logic [31:0]                mem_addr_o,
  output logic [DATA_W-1:0]          mem_wdata_o,
  input  logic                       mem_opdone_i,
  input  logic [DATA_W-1:0]          mem_rdata_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic                       busy_o,
  output logic                       timeout_o
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StIdle, StGrant} state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_grant;
  logic [IdxW-1:0]     r_owner;
  logic [IdxW-1:0]     r_rr;

  logic [1:0]          w_op    [NUM_REQ];
  logic [31:0]         w_addr  [NUM_REQ];
  logic [DATA_W-1:0]   w_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]  w_act;
  logic [NUM_REQ-1:0]  w_elig;
  logic                w_found;
  logic [IdxW-1:0]     w_win;
  logic [NUM_REQ-1:0]  w_win_oh;
  logic [1:0]          w_own_op;
  logic                w_own_act;
  logic                w_wd_hit;

  // Op 10 is illegal and counts as no request.
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      w_op[i]    = req_op_i[2*i +: 2];
      w_addr[i]  = req_addr_i[32*i +: 32];
      w_wdata[i] = req_wdata_i[DATA_W*i +: DATA_W];
      w_act[i]   = (w_op[i] == 2'b01) || (w_op[i] == 2'b11);
    end
  end

  assign w_own_op  = w_op[r_owner];
  assign w_own_act = w_act[r_owner];

  // First eligible master after the last winner, wrapping.
  always_comb begin
    int cand;
    w_found  = 1'b0;
    w_win    = '0;
    w_win_oh = '0;
    cand     = 0;
    for (int k = 1; k <= int'(NUM_REQ); k++) begin
      cand = int'(r_rr) + k;
      if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
      if (!w_found && w_elig[IdxW'(cand)]) begin
        w_found                 = 1'b1;
        w_win                   = IdxW'(cand);
        w_win_oh[IdxW'(cand)]   = 1'b1;
      end
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0]     r_cnt;
  logic [NUM_REQ-1:0]  r_mask;
  logic                r_timeout;

  assign w_wd_hit  = (r_state == StGrant) && !mem_opdone_i &&
                     (r_cnt == CntW'(TIMEOUT_CYCLES - 1));
  assign w_elig    = w_act & ~r_mask;
  assign timeout_o = r_timeout;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_wd_hit     = 1'b0;
  assign w_elig       = w_act;
  assign timeout_o    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_owner <= '0;
      r_rr    <= IdxW'(NUM_REQ - 1);
`ifdef ARB_WATCHDOG_EN
      r_cnt     <= '0;
      r_mask    <= '0;
      r_timeout <= 1'b0;
`endif
    end else begin
`ifdef ARB_WATCHDOG_EN
      r_timeout <= w_wd_hit;
      // A timed-out owner stays masked until it drops its op.
      r_mask    <= (r_mask | (w_wd_hit ? r_grant : '0)) & w_act;
      if (mem_opdone_i || (r_state == StIdle)) begin
        r_cnt <= '0;
      end else if (r_cnt != CntW'(TIMEOUT_CYCLES)) begin
        r_cnt <= r_cnt + 1'b1;
      end
`endif
      case (r_state)
        StIdle: begin
          if (w_found) begin
            r_state <= StGrant;
            r_grant <= w_win_oh;
            r_owner <= w_win;
            r_rr    <= w_win;
          end
        end
        StGrant: begin
          if (!w_own_act || w_wd_hit) begin
            r_state <= StIdle;
            r_grant <= '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    mem_op_o     = 2'b00;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    req_opdone_o = '0;
    if (r_state == StGrant) begin
      if (w_own_op != 2'b10) begin
        mem_op_o    = w_own_op;
        mem_addr_o  = w_addr[r_owner];
        mem_wdata_o = w_wdata[r_owner];
      end
      req_opdone_o = mem_opdone_i ? r_grant : '0;
    end
  end

  assign req_rdata_o = mem_rdata_i;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state == StGrant);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random masters checked against a
// cycle-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int NR = 2;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef ARB_WATCHDOG_EN
  localparam bit WdEn = 1'b1;
`else
  localparam bit WdEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [1:0]    op    [NR];
  logic [31:0]   addr  [NR];
  logic [DW-1:0] wdata [NR];
  logic          mem_opdone;
  logic [DW-1:0] mem_rdata;

  logic [2*NR-1:0]  req_op;
  logic [32*NR-1:0] req_addr;
  logic [DW*NR-1:0] req_wdata;
  logic [NR-1:0]    req_opdone;
  logic [DW-1:0]    req_rdata;
  logic [1:0]       mem_op;
  logic [31:0]      mem_addr;
  logic [DW-1:0]    mem_wdata;
  logic [NR-1:0]    grant;
  logic             busy;
  logic             timeout;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_op[2*g +: 2]      = op[g];
    assign req_addr[32*g +: 32]  = addr[g];
    assign req_wdata[DW*g +: DW] = wdata[g];
  end

  mem_port_arbiter #(
    .NUM_REQ        (NR),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .req_op_i     (req_op),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .req_opdone_o (req_opdone),
    .req_rdata_o  (req_rdata),
    .mem_op_o     (mem_op),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_opdone_i (mem_opdone),
    .mem_rdata_i  (mem_rdata),
    .grant_o      (grant),
    .busy_o       (busy),
    .timeout_o    (timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: current owner (-1 idle), last winner, cycles since grant/ack, mask.
  int         m_owner = -1;
  int         m_last  = NR - 1;
  int         m_cnt   = 0;
  bit         m_to    = 1'b0;
  bit [NR-1:0] m_mask = '0;
  bit [NR-1:0] prev_done = '0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit [NR-1:0] act;
    for (int i = 0; i < NR; i++) act[i] = (op[i] == 2'b01) || (op[i] == 2'b11);
    m_to = 1'b0;
    if (reset) begin
      m_owner = -1;
      m_last  = NR - 1;
      m_cnt   = 0;
      m_mask  = '0;
      return;
    end
    if (m_owner < 0) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (m_last + k) % NR;
        if (act[c] && !m_mask[c]) begin
          m_owner = c;
          m_last  = c;
          m_cnt   = 0;
          break;
        end
      end
    end else if (WdEn && !mem_opdone && (m_cnt + 1 >= TO)) begin
      m_to            = 1'b1;
      m_mask[m_owner] = 1'b1;
      m_owner         = -1;
    end else if (!act[m_owner]) begin
      m_owner = -1;
    end else begin
      m_cnt = mem_opdone ? 0 : m_cnt + 1;
    end
    m_mask &= act;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Compares every output against the model, mid-cycle.
  task automatic check_all();
    logic [NR-1:0] eg, eo;
    logic [1:0]    emop;
    logic [31:0]   ea;
    logic [DW-1:0] ew;
    #4;
    eg = '0; eo = '0; emop = 2'b00; ea = '0; ew = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      if (op[m_owner] != 2'b10) begin
        emop = op[m_owner];
        ea   = addr[m_owner];
        ew   = wdata[m_owner];
      end
      if (mem_opdone) eo[m_owner] = 1'b1;
    end
    check_eq("grant", grant, eg);
    check_eq("busy", busy, m_owner >= 0);
    check_eq("mem_op", mem_op, emop);
    check_eq("mem_addr", mem_addr, ea);
    check_eq("mem_wdata", mem_wdata, ew);
    check_eq("opdone", req_opdone, eo);
    check_eq("rdata", req_rdata, mem_rdata);
    check_eq("timeout", timeout, m_to);
    prev_done = eo;
  endtask

  bit mreq [NR];
  int age  [NR];

  initial begin
    reset      = 1'b1;
    mem_opdone = 1'b0;
    mem_rdata  = '0;
    for (int i = 0; i < NR; i++) begin
      op[i] = 2'b00; addr[i] = '0; wdata[i] = '0; mreq[i] = 1'b0; age[i] = 0;
    end

    tick(); check_all();
    check_eq("rst_grant", grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_op", mem_op, 0);

    // Single read by master 0.
    reset = 1'b0; op[0] = 2'b01; addr[0] = 32'h10;
    tick(); check_all();
    check_eq("rd_grant", grant, 2'b01);
    check_eq("rd_op", mem_op, 2'b01);
    check_eq("rd_addr", mem_addr, 32'h10);
    tick(); check_all();
    tick(); check_all();
    tick(); mem_opdone = 1'b1; mem_rdata = 32'hABCD; check_all();
    check_eq("rd_done", req_opdone, 2'b01);
    check_eq("rd_data", req_rdata, 32'hABCD);
    tick(); op[0] = 2'b00; mem_opdone = 1'b0; check_all();
    tick(); check_all();
    check_eq("rd_release", grant, 2'b00);

    // Write by master 1.
    op[1] = 2'b11; addr[1] = 32'h2C; wdata[1] = 32'h55;
    tick(); check_all();
    check_eq("wr_op", mem_op, 2'b11);
    check_eq("wr_addr", mem_addr, 32'h2C);
    check_eq("wr_data", mem_wdata, 32'h55);
    tick(); mem_opdone = 1'b1; check_all();
    check_eq("wr_done", req_opdone, 2'b10);
    tick(); op[1] = 2'b00; mem_opdone = 1'b0; check_all();
    tick(); check_all();

    // Reset while master 0 owns the port.
    op[0] = 2'b01;
    tick(); check_all();
    check_eq("mid_grant", grant, 2'b01);
    reset = 1'b1;
    tick(); check_all();
    check_eq("mid_rst_grant", grant, 2'b00);
    check_eq("mid_rst_op", mem_op, 2'b00);
    reset = 1'b0; op[1] = 2'b01;
    tick(); check_all();
    check_eq("post_rst_first", grant, 2'b01);
    op[0] = 2'b00; op[1] = 2'b00;
    tick(); check_all();
    tick(); check_all();

`ifdef ARB_WATCHDOG_EN
    // Memory never acks master 0; master 1 waits.
    op[0] = 2'b01; op[1] = 2'b01;
    tick(); check_all();
    check_eq("wd_grant0", grant, 2'b01);
    begin
      int n;
      n = 0;
      while (n < 20 && timeout !== 1'b1) begin
        tick(); check_all(); n++;
      end
      check_eq("wd_cycles", n, TO);
    end
    tick(); check_all();
    check_eq("wd_grant1", grant, 2'b10);
    tick(); mem_opdone = 1'b1; op[1] = 2'b00; check_all();
    tick(); mem_opdone = 1'b0; check_all();
    tick(); check_all();
    check_eq("wd_masked", grant, 2'b00);
    op[0] = 2'b00;
    tick(); check_all();
    op[0] = 2'b01;
    tick(); check_all();
    check_eq("wd_regrant", grant, 2'b01);
    op[0] = 2'b00;
    tick(); check_all();
    tick(); check_all();
`endif

    // Random masters and memory.
    for (int c = 0; c < 800; c++) begin
      tick();
      reset = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NR; i++) begin
        if (mreq[i]) begin
          age[i]++;
          if (prev_done[i] && op[i] != 2'b10) begin
            if ($urandom_range(0, 1) == 1) begin
              addr[i] = $urandom; wdata[i] = $urandom;
            end else begin
              op[i] = 2'b00; mreq[i] = 1'b0;
            end
          end else if (age[i] > 40 || (op[i] == 2'b10 && age[i] > 3)) begin
            op[i] = 2'b00; mreq[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          int r;
          r        = $urandom_range(0, 7);
          op[i]    = (r == 0) ? 2'b10 : ((r < 4) ? 2'b01 : 2'b11);
          mreq[i]  = 1'b1;
          age[i]   = 0;
          addr[i]  = $urandom;
          wdata[i] = $urandom;
        end else begin
          addr[i] = $urandom;
        end
      end
      mem_opdone = (c >= 300 && c < 340) ? 1'b0 : ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      check_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
